// File: rtl/vx_commit_tracker_if.sv
// Issue / commit / drain bus between the issue stage, the warp scheduler and the
// per-warp in-flight tracker. master = issue stage + scheduler, slave = tracker.
interface vx_commit_tracker_if #(
    parameter int ISSUE_CNT      = 2,
    parameter int NUM_WARPS      = 8,
    parameter int WARP_CNT_WIDTH = 3,
    parameter int COMMIT_CNT     = 2,
    parameter int MAX_PENDING    = 15
);
    localparam int CNT_W  = $clog2(COMMIT_CNT + 1);
    localparam int PEND_W = $clog2(MAX_PENDING + 1);

    logic [ISSUE_CNT-1:0]                     issue_valid;
    logic [ISSUE_CNT-1:0][WARP_CNT_WIDTH-1:0] issue_wid;
    logic [ISSUE_CNT-1:0]                     issue_ready;
    logic [ISSUE_CNT-1:0]                     commit_valid;
    logic [ISSUE_CNT-1:0][WARP_CNT_WIDTH-1:0] commit_wid;
    logic [ISSUE_CNT-1:0][CNT_W-1:0]          commit_cnt;
    logic [ISSUE_CNT-1:0]                     committed;
    logic [ISSUE_CNT-1:0][WARP_CNT_WIDTH-1:0] committed_wid;
    logic [NUM_WARPS-1:0][PEND_W-1:0]         pending;
    logic [NUM_WARPS-1:0]                     idle_mask;
    logic                                     drain_req_valid;
    logic [WARP_CNT_WIDTH-1:0]                drain_req_wid;
    logic                                     drain_req_ready;
    logic                                     drain_done;
    logic [WARP_CNT_WIDTH-1:0]                drain_done_wid;
    logic [NUM_WARPS-1:0][31:0]               perf_commits;

    modport master (
        output issue_valid, issue_wid, commit_valid, commit_wid, commit_cnt,
               drain_req_valid, drain_req_wid,
        input  issue_ready, committed, committed_wid, pending, idle_mask,
               drain_req_ready, drain_done, drain_done_wid, perf_commits
    );

    modport slave (
        input  issue_valid, issue_wid, commit_valid, commit_wid, commit_cnt,
               drain_req_valid, drain_req_wid,
        output issue_ready, committed, committed_wid, pending, idle_mask,
               drain_req_ready, drain_done, drain_done_wid, perf_commits
    );
endinterface

// File: rtl/vx_commit_tracker.sv
// Per-warp in-flight instruction counter with issue back-pressure and a drain handshake.
// Optional per-warp commit counters are built when VX_COMMIT_TRACKER_PERF_EN is defined.
module vx_commit_tracker #(
    parameter int ISSUE_CNT      = 2,
    parameter int NUM_WARPS      = 8,
    parameter int WARP_CNT_WIDTH = 3,
    parameter int COMMIT_CNT     = 2,
    parameter int MAX_PENDING    = 15
) (
    input logic               clk,
    input logic               reset,
    vx_commit_tracker_if.slave bus
);
    localparam int PEND_W = $clog2(MAX_PENDING + 1);
    localparam int INC_W  = $clog2(ISSUE_CNT + 1);
    localparam int DEC_W  = $clog2(ISSUE_CNT * COMMIT_CNT + 1);
    localparam int SUM_W  = PEND_W + DEC_W + 1;

    typedef enum logic [1:0] {DR_IDLE, DR_WAIT, DR_DONE} drain_state_e;

    logic [NUM_WARPS-1:0][PEND_W-1:0]         pending_q, pending_d;
    logic [NUM_WARPS-1:0][INC_W-1:0]          inc;
    logic [NUM_WARPS-1:0][DEC_W-1:0]          dec;
    logic [NUM_WARPS-1:0][SUM_W-1:0]          sum;
    logic [NUM_WARPS-1:0]                     underflow, overflow, idle;
    logic [ISSUE_CNT-1:0][SUM_W-1:0]          ahead;
    logic [ISSUE_CNT-1:0]                     ready, fire;
    logic [ISSUE_CNT-1:0]                     cmt_q;
    logic [ISSUE_CNT-1:0][WARP_CNT_WIDTH-1:0] cmt_wid_q;
    drain_state_e                             state_q;
    logic [WARP_CNT_WIDTH-1:0]                drain_wid_q, done_wid_q;
    logic                                     done_q, drain_rdy_q;

    // Lower-index valid slots to the same warp consume headroom first; commits are not credited.
    always_comb begin
        for (int i = 0; i < ISSUE_CNT; i++) begin
            ahead[i] = SUM_W'(pending_q[bus.issue_wid[i]]);
            for (int j = 0; j < i; j++)
                if (bus.issue_valid[j] && bus.issue_wid[j] == bus.issue_wid[i])
                    ahead[i] = ahead[i] + SUM_W'(1);
            ready[i] = (ahead[i] < SUM_W'(MAX_PENDING)) &&
                       !(state_q != DR_IDLE && bus.issue_wid[i] == drain_wid_q);
        end
    end

    assign fire = bus.issue_valid & ready;

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            inc[w] = '0;
            dec[w] = '0;
            for (int i = 0; i < ISSUE_CNT; i++) begin
                if (fire[i] && bus.issue_wid[i] == WARP_CNT_WIDTH'(w))
                    inc[w] = inc[w] + INC_W'(1);
                if (bus.commit_valid[i] && bus.commit_wid[i] == WARP_CNT_WIDTH'(w))
                    dec[w] = dec[w] + DEC_W'(bus.commit_cnt[i]);
            end
            sum[w]       = SUM_W'(pending_q[w]) + SUM_W'(inc[w]);
            underflow[w] = SUM_W'(dec[w]) > sum[w];
            overflow[w]  = !underflow[w] && (sum[w] - SUM_W'(dec[w])) > SUM_W'(MAX_PENDING);
            pending_d[w] = underflow[w] ? '0 : PEND_W'(sum[w] - SUM_W'(dec[w]));
            idle[w]      = (pending_q[w] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q   <= '0;
            cmt_q       <= '0;
            cmt_wid_q   <= '0;
            state_q     <= DR_IDLE;
            drain_wid_q <= '0;
            done_q      <= 1'b0;
            done_wid_q  <= '0;
            drain_rdy_q <= 1'b1;
        end else begin
            pending_q <= pending_d;
            cmt_q     <= bus.commit_valid;
            cmt_wid_q <= bus.commit_wid;
            done_q    <= 1'b0;
            case (state_q)
                DR_IDLE: if (bus.drain_req_valid) begin
                    drain_wid_q <= bus.drain_req_wid;
                    drain_rdy_q <= 1'b0;
                    state_q     <= DR_WAIT;
                end
                // Looks at the registered count, so the last commit costs two cycles to done.
                DR_WAIT: if (pending_q[drain_wid_q] == '0) begin
                    done_q     <= 1'b1;
                    done_wid_q <= drain_wid_q;
                    state_q    <= DR_DONE;
                end
                DR_DONE: begin
                    drain_rdy_q <= 1'b1;
                    state_q     <= DR_IDLE;
                end
                default: begin
                    drain_rdy_q <= 1'b1;
                    state_q     <= DR_IDLE;
                end
            endcase
        end
    end

    assign bus.issue_ready     = ready;
    assign bus.committed       = cmt_q;
    assign bus.committed_wid   = cmt_wid_q;
    assign bus.pending         = pending_q;
    assign bus.idle_mask       = idle;
    assign bus.drain_req_ready = drain_rdy_q;
    assign bus.drain_done      = done_q;
    assign bus.drain_done_wid  = done_wid_q;

`ifdef VX_COMMIT_TRACKER_PERF_EN
    logic [NUM_WARPS-1:0][31:0] perf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++)
                perf_q[w] <= perf_q[w] + 32'(dec[w]);
        end
    end

    assign bus.perf_commits = perf_q;
`else
    assign bus.perf_commits = '0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                assert (!underflow[w]);
                assert (!overflow[w]);
            end
            for (int i = 0; i < ISSUE_CNT; i++)
                assert (!(bus.commit_valid[i] && bus.commit_cnt[i] == '0));
        end
    end
endmodule
